// File: rtl/v850_pkg.sv
`default_nettype none
// ============================================================================
// v850_pkg: shared types for the V850 decode stage (formats, opcodes, record)
// Revision: 1.0
// ============================================================================
package v850_pkg;

    localparam int V850_PC_W = 25;

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_II  = 3'd1,
        FMT_III = 3'd2,
        FMT_IV  = 3'd3,
        FMT_V   = 3'd4,
        FMT_VI  = 3'd5,
        FMT_VII = 3'd6
    } fmt_t;

    localparam logic [5:0] OP_ADDI  = 6'h30;
    localparam logic [5:0] OP_MOVEA = 6'h31;
    localparam logic [5:0] OP_MOVHI = 6'h32;
    localparam logic [5:0] OP_ORI   = 6'h34;
    localparam logic [5:0] OP_XORI  = 6'h35;
    localparam logic [5:0] OP_ANDI  = 6'h36;

    typedef struct packed {
        logic [V850_PC_W-1:0] pc;
        logic [5:0]           opcode;
        logic [4:0]           reg1;
        logic [4:0]           reg2;
        logic [31:0]          imm;
        fmt_t                 fmt;
        logic                 len32;
    } decoded_t;

endpackage
`default_nettype wire

// File: rtl/v850_skid_buffer.sv
`default_nettype none
// ============================================================================
// v850_skid_buffer: two-entry valid/ready buffer (output reg + skid reg), flushable
// Revision: 1.0
// ============================================================================
module v850_skid_buffer
    import v850_pkg::*;
#(
    parameter type T = decoded_t
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic r_out_valid;
    logic r_skid_valid;
    T     r_out_data;
    T     r_skid_data;

    logic w_accept;
    logic w_out_free;

    // The skid entry only fills while the output entry is stalled, so
    // ready depends solely on skid occupancy and is therefore registered.
    assign w_accept   = in_valid && !r_skid_valid && !flush;
    assign w_out_free = !r_out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_data <= in_data;
                end
            end
        end else if (w_accept) begin
            r_skid_data  <= in_data;
            r_skid_valid <= 1'b1;
        end
    end

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: rtl/v850_decode_stage.sv
`default_nettype none
// ============================================================================
// v850_decode_stage: splits fetched V850 instructions into execute-stage fields
// Revision: 1.0
// ============================================================================
module v850_decode_stage
    import v850_pkg::*;
#(
    parameter int PC_W   = V850_PC_W,
    parameter int INSN_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [INSN_W-1:0] instruction_i,
    input  logic [PC_W-1:0]   PC_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PC_W-1:0]   PC_o,
    output logic [5:0]        opcode_o,
    output logic [4:0]        reg1_o,
    output logic [4:0]        reg2_o,
    output logic [31:0]       imm_o,
    output fmt_t              format_o,
    output logic              len32_o
);

    function automatic decoded_t decode(input logic [31:0] insn, input logic [V850_PC_W-1:0] pc);
        decoded_t    d;
        logic [5:0]  op;
        logic [15:0] hi;
        op      = insn[10:5];
        hi      = insn[31:16];
        d.pc     = pc;
        d.opcode = op;
        d.reg1   = insn[4:0];
        d.reg2   = insn[15:11];
        d.len32  = (op[5:4] == 2'b11);

        // Logical immediates zero-extend; every other 32-bit form sign-extends.
        if (op[5:2] == 4'b0100) begin
            d.imm = {{27{insn[4]}}, insn[4:0]};
        end else if (op == OP_ORI || op == OP_XORI || op == OP_ANDI) begin
            d.imm = {16'h0000, hi};
        end else if (op == OP_MOVHI) begin
            d.imm = {hi, 16'h0000};
        end else if (op == OP_ADDI || op == OP_MOVEA || d.len32) begin
            d.imm = {{16{hi[15]}}, hi};
        end else begin
            d.imm = '0;
        end

        casez (op[5:2])
            4'b00??: d.fmt = FMT_I;
            4'b010?: d.fmt = FMT_II;
            4'b011?: d.fmt = FMT_IV;
            4'b100?: d.fmt = FMT_IV;
            4'b1010: d.fmt = FMT_IV;
            4'b1011: d.fmt = FMT_III;
            4'b110?: d.fmt = FMT_VI;
            4'b1110: d.fmt = FMT_VII;
            default: d.fmt = FMT_V;
        endcase
        return d;
    endfunction

    decoded_t w_dec;
    decoded_t w_out;

    assign w_dec = decode(instruction_i[31:0], PC_i);

    v850_skid_buffer #(
        .T (decoded_t)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_i),
        .in_valid  (valid_i),
        .in_ready  (ready_o),
        .in_data   (w_dec),
        .out_valid (valid_o),
        .out_ready (ready_i),
        .out_data  (w_out)
    );

    assign PC_o     = w_out.pc;
    assign opcode_o = w_out.opcode;
    assign reg1_o   = w_out.reg1;
    assign reg2_o   = w_out.reg2;
    assign imm_o    = w_out.imm;
    assign format_o = w_out.fmt;
    assign len32_o  = w_out.len32;

endmodule
`default_nettype wire

// File: tb/tb_v850_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_v850_decode_stage: directed and randomized checks of the decode stage
// Revision: 1.0
// ============================================================================
module tb_v850_decode_stage;
    import v850_pkg::*;

    typedef struct {
        logic [24:0] pc;
        logic [5:0]  op;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] imm;
        fmt_t        fmt;
        logic        len;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [31:0] instruction_i = '0;
    logic [24:0] PC_i = '0;
    logic        ready_o;
    logic        valid_o;
    logic [24:0] PC_o;
    logic [5:0]  opcode_o;
    logic [4:0]  reg1_o;
    logic [4:0]  reg2_o;
    logic [31:0] imm_o;
    fmt_t        format_o;
    logic        len32_o;

    int   n_assert = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    v850_decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .instruction_i (instruction_i),
        .PC_i          (PC_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .PC_o          (PC_o),
        .opcode_o      (opcode_o),
        .reg1_o        (reg1_o),
        .reg2_o        (reg2_o),
        .imm_o         (imm_o),
        .format_o      (format_o),
        .len32_o       (len32_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [24:0] pc, input logic [5:0] op, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [31:0] imm, input fmt_t fmt,
                                input logic len);
        exp_t e;
        e.pc = pc; e.op = op; e.r1 = r1; e.r2 = r2; e.imm = imm; e.fmt = fmt; e.len = len;
        return e;
    endfunction

    // Reference decode from the instruction-set rules, using integer arithmetic.
    function automatic exp_t ref_dec(input logic [31:0] w, input logic [24:0] pc);
        exp_t e;
        int   hw, hi, op, r1;
        hw = int'(w[15:0]);
        hi = int'(w[31:16]);
        op = (hw / 32) % 64;
        r1 = hw % 32;
        e.pc  = pc;
        e.op  = 6'(op);
        e.r1  = 5'(r1);
        e.r2  = 5'(hw / 2048);
        e.len = (op >= 48);
        if (op >= 16 && op < 20)              e.imm = 32'(r1 >= 16 ? r1 - 32 : r1);
        else if (op >= 52 && op <= 54)        e.imm = 32'(hi);
        else if (op == 50)                    e.imm = 32'(hi * 65536);
        else if (op >= 48)                    e.imm = 32'(hi >= 32768 ? hi - 65536 : hi);
        else                                  e.imm = 32'd0;
        if (op < 16)      e.fmt = FMT_I;
        else if (op < 24) e.fmt = FMT_II;
        else if (op < 44) e.fmt = FMT_IV;
        else if (op < 48) e.fmt = FMT_III;
        else if (op < 56) e.fmt = FMT_VI;
        else if (op < 60) e.fmt = FMT_VII;
        else              e.fmt = FMT_V;
        return e;
    endfunction

    task automatic check_out(input string pfx, input exp_t e);
        chk({pfx, " valid"},  64'(valid_o),  64'(1'b1));
        chk({pfx, " pc"},     64'(PC_o),     64'(e.pc));
        chk({pfx, " opcode"}, 64'(opcode_o), 64'(e.op));
        chk({pfx, " reg1"},   64'(reg1_o),   64'(e.r1));
        chk({pfx, " reg2"},   64'(reg2_o),   64'(e.r2));
        chk({pfx, " imm"},    64'(imm_o),    64'(e.imm));
        chk({pfx, " fmt"},    64'(format_o), 64'(e.fmt));
        chk({pfx, " len32"},  64'(len32_o),  64'(e.len));
    endtask

    // One accepted instruction; returns #1 after the accepting edge.
    task automatic offer(input logic [31:0] insn, input logic [24:0] pc);
        valid_i       = 1'b1;
        instruction_i = insn;
        PC_i          = pc;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    initial begin
        exp_t e_add, e_addi5, e_sub;
        bit   exp_v, exp_r;

        e_add   = mk(25'd0, 6'h0E, 5'd1, 5'd2, 32'h0, FMT_I, 1'b0);
        e_addi5 = mk(25'd1, 6'h12, 5'h1F, 5'd2, 32'hFFFF_FFFF, FMT_II, 1'b0);
        e_sub   = mk(25'd2, 6'h0A, 5'd1, 5'd4, 32'h0, FMT_I, 1'b0);

        // Power-on reset
        #1 reset = 1'b1;
        #1;
        chk("por valid", 64'(valid_o), 64'(0));
        chk("por ready", 64'(ready_o), 64'(1));
        chk("por imm",   64'(imm_o),   64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single ADD, latency one
        instruction_i = 32'h0000_11C1; PC_i = 25'd0; valid_i = 1'b1;
        chk("lat pre valid", 64'(valid_o), 64'(0));
        @(posedge clk); #1; valid_i = 1'b0;
        check_out("add", e_add);

        // Back-to-back imm5 and reg-reg forms
        valid_i = 1'b1; instruction_i = 32'h0000_125F; PC_i = 25'd1;
        @(posedge clk); #1;
        check_out("imm5", e_addi5);
        instruction_i = 32'h0000_2141; PC_i = 25'd2;
        @(posedge clk); #1; valid_i = 1'b0;
        check_out("b2b", e_sub);

        // 32-bit immediate forms
        offer({16'h000B, 16'h1EC1}, 25'd3);
        check_out("andi", mk(25'd3, 6'h36, 5'd1, 5'd3, 32'h0000_000B, FMT_VI, 1'b1));
        offer({16'h8000, 16'h1EC1}, 25'd4);
        check_out("andi8000", mk(25'd4, 6'h36, 5'd1, 5'd3, 32'h0000_8000, FMT_VI, 1'b1));
        offer({16'h8000, 16'h1E01}, 25'd5);
        check_out("addi8000", mk(25'd5, 6'h30, 5'd1, 5'd3, 32'hFFFF_8000, FMT_VI, 1'b1));
        offer({16'h1234, 16'h1E41}, 25'd6);
        check_out("movhi", mk(25'd6, 6'h32, 5'd1, 5'd3, 32'h1234_0000, FMT_VI, 1'b1));
        @(posedge clk); #1;
        chk("drain valid", 64'(valid_o), 64'(0));

        // Stall: two accepted, third held off, then ordered drain
        ready_i = 1'b0;
        e_add.pc = 25'd10; e_addi5.pc = 25'd11; e_sub.pc = 25'd12;
        offer(32'h0000_11C1, 25'd10);
        chk("stall ready1", 64'(ready_o), 64'(1));
        offer(32'h0000_125F, 25'd11);
        chk("stall ready0", 64'(ready_o), 64'(0));
        check_out("stall held", e_add);
        valid_i = 1'b1; instruction_i = 32'h0000_2141; PC_i = 25'd12;
        @(posedge clk); #1;
        chk("stall ready still0", 64'(ready_o), 64'(0));
        check_out("stall stable", e_add);
        ready_i = 1'b1;
        @(posedge clk); #1;
        check_out("stall 2nd", e_addi5);
        chk("stall ready back", 64'(ready_o), 64'(1));
        @(posedge clk); #1; valid_i = 1'b0;
        check_out("stall 3rd", e_sub);
        @(posedge clk); #1;
        chk("stall empty", 64'(valid_o), 64'(0));

        // Flush with both entries full and an offer pending
        ready_i = 1'b0;
        offer(32'h0000_11C1, 25'd13);
        offer(32'h0000_125F, 25'd14);
        flush_i = 1'b1; valid_i = 1'b1; instruction_i = 32'h0000_2141; PC_i = 25'd15;
        @(posedge clk); #1; flush_i = 1'b0; valid_i = 1'b0;
        chk("flush valid", 64'(valid_o), 64'(0));
        chk("flush ready", 64'(ready_o), 64'(1));
        // Flush while ready_o is high: the offered instruction must be dropped
        offer(32'h0000_11C1, 25'd16);
        flush_i = 1'b1; valid_i = 1'b1; instruction_i = 32'h0000_2141; PC_i = 25'd17;
        @(posedge clk); #1; flush_i = 1'b0; valid_i = 1'b0;
        chk("flush wins valid", 64'(valid_o), 64'(0));
        chk("flush wins ready", 64'(ready_o), 64'(1));
        ready_i = 1'b1;
        offer(32'h0000_49E1, 25'd20);
        check_out("cmp", mk(25'd20, 6'h0F, 5'd1, 5'd9, 32'h0, FMT_I, 1'b0));
        @(posedge clk); #1;
        chk("post flush empty", 64'(valid_o), 64'(0));

        // Asynchronous reset mid-stream
        ready_i = 1'b0;
        offer(32'h0000_125F, 25'd30);
        offer(32'h0000_11C1, 25'd31);
        #2 reset = 1'b1;
        #1;
        chk("arst valid", 64'(valid_o), 64'(0));
        chk("arst ready", 64'(ready_o), 64'(1));
        chk("arst imm",   64'(imm_o),   64'(0));
        chk("arst pc",    64'(PC_o),    64'(0));
        valid_i = 1'b1; instruction_i = 32'h0000_2141; PC_i = 25'd32;
        @(posedge clk); #1;
        reset = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("arst no output", 64'(valid_o), 64'(0));

        // Randomized traffic against a two-deep in-order queue model
        @(negedge clk);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            exp_v = (q.size() > 0);
            exp_r = (q.size() < 2);
            chk("rnd valid", 64'(valid_o), 64'(exp_v));
            chk("rnd ready", 64'(ready_o), 64'(exp_r));
            if (exp_v) check_out("rnd", q[0]);
            valid_i       = (($urandom % 4) != 0);
            ready_i       = (($urandom % 3) != 0);
            flush_i       = (($urandom % 50) == 0);
            instruction_i = $urandom;
            PC_i          = 25'($urandom);
            if (flush_i) begin
                q.delete();
            end else begin
                if (exp_v && ready_i) void'(q.pop_front());
                if (valid_i && exp_r) q.push_back(ref_dec(instruction_i, PC_i));
            end
            @(negedge clk);
        end
        valid_i = 1'b0;
        flush_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
